// File: rtl/lu_cache_ctrl.sv
// rtl/lu_cache_ctrl.sv - bit-serial NOR/NAND/XOR/XNOR unit behind a direct-mapped result cache
module lu_cache_ctrl #(
    parameter int WIDTH      = 3,
    parameter int INDEX_BITS = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_in,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_out,
    output logic             resp_hit,
    input  logic             flush,
    output logic             busy,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    localparam int KEY_W = WIDTH + 2;
    localparam int TAG_W = KEY_W - INDEX_BITS;
    localparam int LINES = 1 << INDEX_BITS;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_EVAL, S_RESP} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_op;
    logic [WIDTH-1:0]      r_in;
    logic                  r_lk_phase;
    logic                  r_rd_valid;
    logic [TAG_W-1:0]      r_rd_tag;
    logic                  r_rd_res;
    logic [BIT_W-1:0]      r_bit;
    logic                  r_acc;
    logic                  r_resp_out;
    logic                  r_resp_hit;
    logic [CNT_W-1:0]      r_hit_cnt;
    logic [CNT_W-1:0]      r_miss_cnt;
    logic [LINES-1:0]      r_valid;
    logic [TAG_W-1:0]      r_tag [LINES];
    logic [LINES-1:0]      r_res;

    logic [KEY_W-1:0]      w_key;
    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_hit;
    logic                  w_in_bit;
    logic                  w_acc_next;
    logic                  w_last;
    logic                  w_result;
    logic                  w_fill;

    assign w_key    = {r_op, r_in};
    assign w_idx    = w_key[INDEX_BITS-1:0];
    assign w_tag    = w_key[KEY_W-1:INDEX_BITS];
    assign w_hit    = r_rd_valid && (r_rd_tag == w_tag);
    assign w_in_bit = r_in[r_bit];
    assign w_last   = (r_bit == BIT_W'(WIDTH - 1));
    assign w_result = w_acc_next ^ (r_op != 2'b10);
    assign w_fill   = (r_state == S_EVAL) && w_last;

    always_comb begin
        w_acc_next = r_acc ^ w_in_bit;
        case (r_op)
            2'b00:   w_acc_next = r_acc | w_in_bit;
            2'b01:   w_acc_next = r_acc & w_in_bit;
            default: w_acc_next = r_acc ^ w_in_bit;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (req_valid) w_next = S_LOOKUP;
            S_LOOKUP: if (r_lk_phase) w_next = w_hit ? S_RESP : S_EVAL;
            S_EVAL:   if (w_last) w_next = S_RESP;
            S_RESP:   if (resp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // LOOKUP reads the line into registers first, then decides on the snapshot,
    // so a flush landing during LOOKUP never affects the hit decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_in       <= '0;
            r_lk_phase <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_tag   <= '0;
            r_rd_res   <= 1'b0;
            r_bit      <= '0;
            r_acc      <= 1'b0;
            r_resp_out <= 1'b0;
            r_resp_hit <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_op       <= req_op;
                    r_in       <= req_in;
                    r_lk_phase <= 1'b0;
                end
                S_LOOKUP: if (!r_lk_phase) begin
                    r_lk_phase <= 1'b1;
                    r_rd_valid <= r_valid[w_idx];
                    r_rd_tag   <= r_tag[w_idx];
                    r_rd_res   <= r_res[w_idx];
                end else begin
                    r_lk_phase <= 1'b0;
                    if (w_hit) begin
                        if (r_hit_cnt != {CNT_W{1'b1}}) r_hit_cnt <= r_hit_cnt + 1'b1;
                        r_resp_out <= r_rd_res;
                        r_resp_hit <= 1'b1;
                    end else begin
                        if (r_miss_cnt != {CNT_W{1'b1}}) r_miss_cnt <= r_miss_cnt + 1'b1;
                        r_bit <= '0;
                        r_acc <= (r_op == 2'b01);
                    end
                end
                S_EVAL: begin
                    r_acc <= w_acc_next;
                    r_bit <= r_bit + BIT_W'(1);
                    if (w_last) begin
                        r_resp_out <= w_result;
                        r_resp_hit <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Flush takes priority over a fill landing on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_idx] <= 1'b1;
            r_tag[w_idx]   <= w_tag;
            r_res[w_idx]   <= w_result;
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign busy       = (r_state != S_IDLE);
    assign resp_out   = r_resp_out;
    assign resp_hit   = r_resp_hit;
    assign hit_cnt    = r_hit_cnt;
    assign miss_cnt   = r_miss_cnt;
endmodule
